// File: rtl/burst_imem_pkg.sv
// Shared state encoding and index-width helpers for the burst instruction memory.
package burst_imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    // Index width for a count of n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    localparam int WORD_IDX_W     = 30;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ROWS       = 512;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_LATENCY    = 10;
    localparam int DEF_ROW_IDX_W  = idx_width(DEF_ROWS);
    localparam int DEF_BEAT_IDX_W = idx_width(DEF_BURST_LEN);

endpackage

// File: rtl/imem_array.sv
// Backing store: one synchronous write port and one combinational read port.
module imem_array
    import burst_imem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int AW         = idx_width(ROWS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [ROWS];

    // Word write; storage has no reset so loaded code survives a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/burst_inst_memory.sv
// Slow main-memory model: accepts a block read, waits LATENCY cycles, then
// streams BURST_LEN registered beats from the aligned block.
module burst_inst_memory
    import burst_imem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ROWS       = DEF_ROWS,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               Req_valid,
    output logic                               Req_ready,
    input  logic [31:0]                        Req_address,
    output logic                               Resp_valid,
    output logic [DATA_WIDTH-1:0]              Resp_data,
    output logic [idx_width(BURST_LEN)-1:0]    Resp_index,
    output logic                               Resp_last,
    input  logic                               Wr_en,
    input  logic [31:0]                        Wr_address,
    input  logic [DATA_WIDTH-1:0]              Wr_data
);

    localparam int AW = idx_width(ROWS);
    localparam int BW = idx_width(BURST_LEN);
    localparam int CW = idx_width(LATENCY + 1);

    localparam logic [WORD_IDX_W-1:0] ROW_MASK   = WORD_IDX_W'(ROWS - 1);
    localparam logic [AW-1:0]         BLOCK_MASK = ~AW'(BURST_LEN - 1);
    localparam logic [BW-1:0]         LAST_BEAT  = BW'(BURST_LEN - 1);
    localparam logic [CW-1:0]         WAIT_LOAD  = CW'(LATENCY - 1);
    localparam logic [CW-1:0]         WAIT_EXIT  = CW'(1);

    state_t                state_r;
    logic [CW-1:0]         wait_cnt_r;
    logic [BW-1:0]         beat_r;
    logic [AW-1:0]         base_r;
    logic [AW-1:0]         req_idx_s;
    logic [AW-1:0]         wr_idx_s;
    logic [AW-1:0]         rd_idx_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  unused_addr_s;

    // Byte offsets within a word carry no meaning for a word-wide store.
    assign unused_addr_s = ^{Req_address[1:0], Wr_address[1:0]};

    assign req_idx_s = AW'(Req_address[31:2] & ROW_MASK);
    assign wr_idx_s  = AW'(Wr_address[31:2] & ROW_MASK);
    assign rd_idx_s  = AW'((WORD_IDX_W'(base_r) + WORD_IDX_W'(beat_r)) & ROW_MASK);

    assign Req_ready = (state_r == IDLE);

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ROWS),
        .AW         (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (Wr_en),
        .wr_idx  (wr_idx_s),
        .wr_data (Wr_data),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s)
    );

    // Request FSM with registered beat outputs; read data is sampled before
    // any same-edge write lands, giving read-before-write on collisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
            beat_r     <= '0;
            base_r     <= '0;
            Resp_valid <= 1'b0;
            Resp_data  <= '0;
            Resp_index <= '0;
            Resp_last  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    Resp_valid <= 1'b0;
                    Resp_last  <= 1'b0;
                    Resp_index <= '0;
                    beat_r     <= '0;
                    if (Req_valid) begin
                        base_r <= req_idx_s & BLOCK_MASK;
                        if (LATENCY == 1) begin
                            state_r <= BURST;
                        end else begin
                            state_r    <= WAIT;
                            wait_cnt_r <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    Resp_valid <= 1'b0;
                    Resp_last  <= 1'b0;
                    wait_cnt_r <= wait_cnt_r - CW'(1);
                    if (wait_cnt_r == WAIT_EXIT) begin
                        state_r <= BURST;
                        beat_r  <= '0;
                    end
                end
                BURST: begin
                    Resp_valid <= 1'b1;
                    Resp_data  <= rd_data_s;
                    Resp_index <= beat_r;
                    Resp_last  <= (beat_r == LAST_BEAT);
                    if (beat_r == LAST_BEAT) begin
                        state_r <= IDLE;
                        beat_r  <= '0;
                    end else begin
                        beat_r <= beat_r + BW'(1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= '0;
                    beat_r     <= '0;
                    Resp_valid <= 1'b0;
                    Resp_last  <= 1'b0;
                    Resp_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_inst_memory.sv
// Directed bench for burst_inst_memory at default parameters (LATENCY=10, BURST_LEN=4, ROWS=512).
module tb_burst_inst_memory;

    localparam int DW   = 32;
    localparam int ROWS = 512;
    localparam int BL   = 4;
    localparam int LAT  = 10;

    logic          clk;
    logic          reset_n;
    logic          Req_valid;
    logic          Req_ready;
    logic [31:0]   Req_address;
    logic          Resp_valid;
    logic [DW-1:0] Resp_data;
    logic [1:0]    Resp_index;
    logic          Resp_last;
    logic          Wr_en;
    logic [31:0]   Wr_address;
    logic [DW-1:0] Wr_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tb_mem [ROWS];

    typedef struct packed {
        logic [31:0] addr;
        int          exp_base;
        int          wr_edge;
        int          wr_word;
        logic [31:0] wr_data;
    } vec_t;

    vec_t vecs [9];

    burst_inst_memory #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .BURST_LEN  (BL),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Req_valid   (Req_valid),
        .Req_ready   (Req_ready),
        .Req_address (Req_address),
        .Resp_valid  (Resp_valid),
        .Resp_data   (Resp_data),
        .Resp_index  (Resp_index),
        .Resp_last   (Resp_last),
        .Wr_en       (Wr_en),
        .Wr_address  (Wr_address),
        .Wr_data     (Wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request at edge E0 and check every edge through E(LAT+BL).
    task automatic run_burst(input vec_t v, input int id);
        logic [31:0] held;
        logic [31:0] exp_d;
        held        = 32'h0;
        Req_valid   = 1'b1;
        Req_address = v.addr;
        for (int e = 0; e <= LAT + BL; e++) begin
            if (e == v.wr_edge) begin
                Wr_en      = 1'b1;
                Wr_address = 32'(v.wr_word) * 32'd4;
                Wr_data    = v.wr_data;
            end else begin
                Wr_en = 1'b0;
            end
            tick();
            Req_valid = 1'b0;
            if (e == 0) begin
                check($sformatf("v%0d_e0_ready", id), {31'd0, Req_ready}, 32'd0);
            end else begin
                check($sformatf("v%0d_e%0d_ready", id, e), {31'd0, Req_ready},
                      (e >= LAT + BL - 1) ? 32'd1 : 32'd0);
                if (e >= LAT && e < LAT + BL) begin
                    exp_d = tb_mem[(v.exp_base + e - LAT) % ROWS];
                    held  = exp_d;
                    check($sformatf("v%0d_e%0d_valid", id, e), {31'd0, Resp_valid}, 32'd1);
                    check($sformatf("v%0d_e%0d_index", id, e), {30'd0, Resp_index}, 32'(e - LAT));
                    check($sformatf("v%0d_e%0d_last", id, e), {31'd0, Resp_last},
                          (e == LAT + BL - 1) ? 32'd1 : 32'd0);
                    check($sformatf("v%0d_e%0d_data", id, e), Resp_data, exp_d);
                end else begin
                    check($sformatf("v%0d_e%0d_valid", id, e), {31'd0, Resp_valid}, 32'd0);
                    check($sformatf("v%0d_e%0d_last", id, e), {31'd0, Resp_last}, 32'd0);
                end
                if (e == LAT + BL) begin
                    check($sformatf("v%0d_hold_data", id), Resp_data, held);
                end
            end
            if (e == v.wr_edge) begin
                tb_mem[v.wr_word] = v.wr_data;
            end
        end
        Wr_en = 1'b0;
    endtask

    initial begin
        vec_t fresh;
        reset_n     = 1'b1;
        Req_valid   = 1'b0;
        Req_address = 32'h0;
        Wr_en       = 1'b0;
        Wr_address  = 32'h0;
        Wr_data     = 32'h0;

        // Hand-computed vectors: {address, expected base word, write edge, word, data}
        vecs[0] = '{32'h0000_0014,   4, -1, 0, 32'h0};
        vecs[1] = '{32'h0000_0FF8, 508, -1, 0, 32'h0};
        vecs[2] = '{32'h0000_001F,   4, -1, 0, 32'h0};
        vecs[3] = '{32'h1000_0800,   0, -1, 0, 32'h0};
        vecs[4] = '{32'h0000_07FC, 508, -1, 0, 32'h0};
        vecs[5] = '{32'h0000_0000,   0, 12, 2, 32'hDEAD_BEEF};
        vecs[6] = '{32'h0000_0020,   8,  3, 2, 32'h1000_0002};
        vecs[7] = '{32'h0000_0000,   0, 11, 2, 32'hDEAD_BEEF};
        vecs[8] = '{32'h0000_000C,   0, -1, 0, 32'h0};

        // Asynchronous reset between clock edges.
        #2 reset_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, Req_ready}, 32'd1);
        check("rst_valid", {31'd0, Resp_valid}, 32'd0);
        check("rst_data", Resp_data, 32'd0);
        check("rst_last", {31'd0, Resp_last}, 32'd0);
        check("rst_index", {30'd0, Resp_index}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Load every word; byte offsets vary to exercise the ignored low bits.
        for (int i = 0; i < ROWS; i++) begin
            Wr_en      = 1'b1;
            Wr_address = 32'(i) * 32'd4 + 32'(i % 4);
            Wr_data    = 32'h1000_0000 + 32'(i);
            tick();
            tb_mem[i]  = 32'h1000_0000 + 32'(i);
        end
        Wr_en = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            run_burst(vecs[v], v);
        end

        // Second request held during WAIT: accepted at E14, first beat on E24.
        Req_valid   = 1'b1;
        Req_address = 32'h0000_0014;
        tick();
        Req_valid = 1'b0;
        for (int e = 1; e <= 28; e++) begin
            if (e == 2) begin
                Req_valid   = 1'b1;
                Req_address = 32'h0000_0040;
            end
            if (e == 15) begin
                Req_valid = 1'b0;
            end
            tick();
            check($sformatf("ign_e%0d_ready", e), {31'd0, Req_ready},
                  (e == 13 || e >= 27) ? 32'd1 : 32'd0);
            if (e >= 10 && e <= 13) begin
                check($sformatf("ign_e%0d_valid", e), {31'd0, Resp_valid}, 32'd1);
                check($sformatf("ign_e%0d_data", e), Resp_data, tb_mem[4 + e - 10]);
            end else if (e >= 24 && e <= 27) begin
                check($sformatf("ign_e%0d_valid", e), {31'd0, Resp_valid}, 32'd1);
                check($sformatf("ign_e%0d_index", e), {30'd0, Resp_index}, 32'(e - 24));
                check($sformatf("ign_e%0d_data", e), Resp_data, tb_mem[16 + e - 24]);
            end else begin
                check($sformatf("ign_e%0d_valid", e), {31'd0, Resp_valid}, 32'd0);
            end
        end

        // Reset after beat 1 aborts the burst.
        Req_valid   = 1'b1;
        Req_address = 32'h0000_0000;
        tick();
        Req_valid = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
        end
        check("mid_beat1_valid", {31'd0, Resp_valid}, 32'd1);
        check("mid_beat1_index", {30'd0, Resp_index}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, Resp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, Req_ready}, 32'd1);
        check("mid_rst_data", Resp_data, 32'd0);
        check("mid_rst_last", {31'd0, Resp_last}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int e = 0; e < 6; e++) begin
            tick();
            check($sformatf("post_rst%0d_valid", e), {31'd0, Resp_valid}, 32'd0);
            check($sformatf("post_rst%0d_ready", e), {31'd0, Req_ready}, 32'd1);
        end
        fresh = '{32'h0000_0004, 0, -1, 0, 32'h0};
        run_burst(fresh, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
